cgra_obi_mem_responder: RTL and testbench
=========================================

// Module: cgra_obi_mem_responder
// PURPOSE
// - OBI subordinate (responder) that terminates one CGRA master port (one element of masters_req_o/masters_resp_i).
// - Backed by an internal word-addressed memory, with a programmable response latency.
// - Used as the far end of the CGRA memory interface in block-level benches and standalone SoC bring-up.
// - Provides stall injection, out-of-range error flagging and transaction counters.
// PARAMETERS
// - MEM_WORDS   1024          memory depth in 32-bit words; power of two, >= 2
// - BASE_ADDR   32'h0000_0000 byte address mapped to word 0; MEM_WORDS*4-aligned
// - LATENCY     1             cycles from handshake to rvalid; range 1..8
// PORTS
// - clk_i       in   1   clock; single domain
// - rst_ni      in   1   asynchronous active-low reset
// - obi_req_i   in   obi_req_t   OBI A-channel from master: req, we, be[3:0], addr[31:0], wdata[31:0]
// - obi_resp_o  out  obi_resp_t  OBI response to master: gnt, rvalid, rdata[31:0]
// - stall_i     in   1   when high, gnt is forced low (back-pressure injection)
// - err_o       out  1   sticky out-of-range access flag
// - err_clr_i   in   1   synchronous clear of err_o
// - rd_cnt_o    out  32  accepted read count, wraps at 2^32
// - wr_cnt_o    out  32  accepted write count, wraps at 2^32
// BEHAVIOUR
// - Reset values: gnt=0, rvalid=0, rdata=0, err_o=0, rd_cnt_o=0, wr_cnt_o=0, delay line cleared.
// - Memory contents are not reset.
// - gnt = req & ~stall_i, combinational, same cycle.
// - Handshake = req & gnt at a rising edge; at most one accepted per cycle; back-to-back supported.
// - Offset = addr - BASE_ADDR; word index = offset[2 +: $clog2(MEM_WORDS)]; addr[1:0] ignored.
// - Out of range when addr < BASE_ADDR or offset >= MEM_WORDS*4.
// - Write handshake: for each be[i]=1, byte i of mem[idx] <= wdata byte i at that edge.
//   - be=4'b0000 is a legal no-op write.
//   - Response rdata = 0.
// - Read handshake: rdata = mem[idx] as it was before any write in the same edge.
//   - Data is captured at the handshake, so a later write cannot change a pending read.
// - Every handshake (read or write) yields exactly one response.
//   - rvalid is high for exactly one cycle, LATENCY cycles after the handshake edge.
//   - Responses return in order; there is no rready, so responses cannot be stalled.
// - Outstanding responses never exceed LATENCY; no other grant limit applies.
// - rdata when rvalid=0 is 0.
// - Out of range: write has no memory effect; read returns 32'h0; both still get rvalid.
//   - err_o sets the cycle after the handshake.
// - err_clr_i and a new error in the same cycle: set wins.
// - Counters increment on the handshake edge; 32'hFFFF_FFFF + 1 wraps to 0.
// - stall_i rising while req is held: no handshake that cycle; the master keeps request fields stable (OBI rule).
// - Reset mid-operation: all pending responses dropped, no rvalid after reset release until a new handshake.
// STRUCTURE
// - obi_pkg: obi_req_t / obi_resp_t (existing).
// - cgra_pkg: add CGRA_RESP_LAT_MAX = 8 and the out-of-range read value constant (32'h0).
// - Sub-module cgra_obi_resp_delay: LATENCY-stage shift register of {valid, rdata[31:0]}, async reset of valid bits.
// - Top holds address decode, memory array, error flag and counters.
// TESTING
// - LATENCY=1: write 32'hCAFE_F00D to 0x10, then read 0x10 -> rvalid one cycle after each gnt, rdata=32'hCAFE_F00D.
// - be=4'b0101, wdata=32'h1122_3344 over 32'hAAAA_AAAA -> read 32'hAA22_AA44.
// - LATENCY=3: 6 back-to-back reads -> gnt every cycle, 6 consecutive rvalid pulses starting 3 cycles after the first gnt, order preserved.
// - stall_i=1 for 4 cycles with req held -> gnt=0 throughout, no counter change; stall_i=0 -> single gnt, rd_cnt_o +1.
// - Read of BASE_ADDR+MEM_WORDS*4 -> rdata=0, rvalid asserted, err_o=1; err_clr_i -> err_o=0 next cycle.
// - LATENCY=4: rst_ni pulsed 2 cycles after a read handshake -> no rvalid ever returned, counters 0.

Source files
------------

// File: rtl/cgra_pkg.sv
// CGRA-level constants and helper types.
//   CGRA_RESP_LAT_MAX : upper bound on the responder's programmable latency
//   CGRA_OOR_RDATA    : read data returned for out-of-range accesses
//   cgra_resp_beat_t  : one stage of the response delay line
package cgra_pkg;

  localparam int unsigned CGRA_RESP_LAT_MAX = 8;
  localparam logic [31:0] CGRA_OOR_RDATA    = 32'h0;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } cgra_resp_beat_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI bus types shared by every OBI master/subordinate in the CGRA slice.
//   obi_req_t  : A-channel from master (req, we, be, addr, wdata)
//   obi_resp_t : response to master (gnt, rvalid, rdata)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cgra_obi_resp_delay.sv
// Fixed-length response pipe: every beat entering at in_* leaves at out_*
// exactly LATENCY clock edges later, in order, with no back-pressure.
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears all stages)
//   in_valid_i     : a response is launched this cycle
//   in_data_i      : its read data (already zero for writes / errors)
//   out_valid_o    : response valid (one cycle per launched beat)
//   out_data_o     : response data, forced to zero when out_valid_o is low
module cgra_obi_resp_delay
  import cgra_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  output logic [31:0] out_data_o
);

  genvar gi;
  generate
    for (gi = 0; gi < int'(LATENCY); gi++) begin : g_stage
      cgra_resp_beat_t beat_reg;
      cgra_resp_beat_t beat_next;

      if (gi == 0) begin : g_head
        assign beat_next = '{valid: in_valid_i, data: in_data_i};
      end else begin : g_body
        assign beat_next = g_stage[gi-1].beat_reg;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          beat_reg <= '0;
        end else begin
          beat_reg <= beat_next;
        end
      end
    end
  endgenerate

  assign out_valid_o = g_stage[LATENCY-1].beat_reg.valid;
  assign out_data_o  = out_valid_o ? g_stage[LATENCY-1].beat_reg.data : 32'h0;

endmodule

// File: rtl/cgra_obi_mem_responder.sv
// OBI subordinate terminating one CGRA master port, backed by a word-addressed
// byte-writable memory with a fixed response latency.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   obi_req_i     : OBI A-channel from the master
//   obi_resp_o    : gnt (combinational), rvalid/rdata (LATENCY cycles later)
//   stall_i       : forces gnt low while high
//   err_o         : sticky out-of-range flag, err_clr_i clears (a new error wins)
//   rd_cnt_o      : accepted reads, wrapping
//   wr_cnt_o      : accepted writes, wrapping
// LATENCY must be in 1..CGRA_RESP_LAT_MAX; MEM_WORDS a power of two >= 2.
module cgra_obi_mem_responder
  import obi_pkg::*;
  import cgra_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  input  logic      stall_i,
  output logic      err_o,
  input  logic      err_clr_i,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             gnt;
  logic             rd_hs;
  logic             wr_hs;
  logic [31:0]      mem_word;
  logic [31:0]      resp_data;

  logic        err_reg,    err_next;
  logic [31:0] rd_cnt_reg, rd_cnt_next;
  logic [31:0] wr_cnt_reg, wr_cnt_next;

  // Address decode. The explicit lower-bound test matters because the
  // subtraction wraps for addresses below BASE_ADDR.
  assign offset   = obi_req_i.addr - BASE_ADDR;
  assign in_range = (obi_req_i.addr >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign idx      = offset[2 +: IDX_W];

  // Grant is held low during reset so no request can be seen as accepted.
  assign gnt   = obi_req_i.req & ~stall_i & rst_ni;
  assign rd_hs = gnt & ~obi_req_i.we;
  assign wr_hs = gnt &  obi_req_i.we;

  // One byte lane per array keeps byte-enable writes mappable onto RAM.
  // A read and a write never share an edge (single accept per cycle), so the
  // read below always sees the pre-edge contents.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_bytes [MEM_WORDS];

      always_ff @(posedge clk_i) begin
        if (wr_hs && in_range && obi_req_i.be[gi]) begin
          mem_bytes[idx] <= obi_req_i.wdata[8*gi +: 8];
        end
      end

      assign mem_word[8*gi +: 8] = mem_bytes[idx];
    end
  endgenerate

  // Read data is captured into the delay line at the handshake; writes and
  // out-of-range reads launch a zero word.
  assign resp_data = (rd_hs && in_range) ? mem_word : CGRA_OOR_RDATA;

  cgra_obi_resp_delay #(
    .LATENCY (LATENCY)
  ) u_resp_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (gnt),
    .in_data_i   (resp_data),
    .out_valid_o (obi_resp_o.rvalid),
    .out_data_o  (obi_resp_o.rdata)
  );

  assign obi_resp_o.gnt = gnt;

  always_comb begin
    err_next    = err_reg;
    rd_cnt_next = rd_cnt_reg + 32'(rd_hs);
    wr_cnt_next = wr_cnt_reg + 32'(wr_hs);
    if (err_clr_i) begin
      err_next = 1'b0;
    end
    // Set takes priority over a simultaneous clear.
    if (gnt && !in_range) begin
      err_next = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_reg    <= 1'b0;
      rd_cnt_reg <= 32'h0;
      wr_cnt_reg <= 32'h0;
    end else begin
      err_reg    <= err_next;
      rd_cnt_reg <= rd_cnt_next;
      wr_cnt_reg <= wr_cnt_next;
    end
  end

  assign err_o    = err_reg;
  assign rd_cnt_o = rd_cnt_reg;
  assign wr_cnt_o = wr_cnt_reg;

endmodule

// File: tb/tb_cgra_obi_mem_responder.sv
// Scoreboard bench for cgra_obi_mem_responder. Three instances cover
// LATENCY 1, 3 and 4; each accepted request pushes its expected response
// (instance, data, sample cycle) and an independent monitor pops and compares.
module tb_cgra_obi_mem_responder;
  import obi_pkg::*;

  typedef struct {
    int          inst;
    logic [31:0] data;
    longint      cyc;
  } exp_t;

  logic        clk;
  logic        rst_n   [3];
  obi_req_t    req_s   [3];
  obi_resp_t   resp_s  [3];
  logic        stall   [3];
  logic        err_clr [3];
  logic        err     [3];
  logic [31:0] rd_cnt  [3];
  logic [31:0] wr_cnt  [3];

  int     lat_of [3] = '{1, 3, 4};
  int     rd_exp [3] = '{0, 0, 0};
  int     wr_exp [3] = '{0, 0, 0};
  exp_t   exp_q[$];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     waited;

  cgra_obi_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .obi_req_i(req_s[0]), .obi_resp_o(resp_s[0]),
    .stall_i(stall[0]), .err_o(err[0]), .err_clr_i(err_clr[0]),
    .rd_cnt_o(rd_cnt[0]), .wr_cnt_o(wr_cnt[0]));

  cgra_obi_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_1000), .LATENCY(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .obi_req_i(req_s[1]), .obi_resp_o(resp_s[1]),
    .stall_i(stall[1]), .err_o(err[1]), .err_clr_i(err_clr[1]),
    .rd_cnt_o(rd_cnt[1]), .wr_cnt_o(wr_cnt[1]));

  cgra_obi_mem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .LATENCY(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .obi_req_i(req_s[2]), .obi_resp_o(resp_s[2]),
    .stall_i(stall[2]), .err_o(err[2]), .err_clr_i(err_clr[2]),
    .rd_cnt_o(rd_cnt[2]), .wr_cnt_o(wr_cnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: every rvalid must match the head of the scoreboard in instance,
  // data and arrival cycle.
  initial forever begin
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (resp_s[i].rvalid) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].inst != i) begin
          errors++;
          $display("FAIL unexpected_rvalid inst%0d: got rdata %h at cycle %0d, required no response",
                   i, resp_s[i].rdata, cyc);
        end else begin
          e = exp_q.pop_front();
          if (resp_s[i].rdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL resp inst%0d: got rdata %h cycle %0d, required rdata %h cycle %0d",
                     i, resp_s[i].rdata, cyc, e.data, e.cyc);
          end else begin
            $display("resp inst%0d rdata %h cycle %0d ok", i, resp_s[i].rdata, cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  // Called at a falling edge; holds the request until granted and returns at
  // the falling edge after the accepting rising edge.
  task automatic txn(input int inst, input logic we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input bit track, output int nwait);
    bit granted;
    granted = 1'b0;
    nwait   = 0;
    req_s[inst].req   = 1'b1;
    req_s[inst].we    = we;
    req_s[inst].be    = be;
    req_s[inst].addr  = addr;
    req_s[inst].wdata = wdata;
    for (int w = 0; w < 16 && !granted; w++) begin
      #1;
      if (resp_s[inst].gnt) begin
        granted = 1'b1;
        if (track) exp_q.push_back('{inst, exp_data, cyc + longint'(lat_of[inst])});
        if (we) wr_exp[inst]++;
        else    rd_exp[inst]++;
        $display("req  inst%0d we=%0b be=%b addr %h wdata %h exp %h", inst, we, be, addr, wdata, exp_data);
      end else begin
        nwait++;
      end
      @(negedge clk);
    end
    checks++;
    if (!granted) begin
      errors++;
      $display("FAIL gnt_timeout inst%0d: got no gnt, required gnt for addr %h", inst, addr);
    end
  endtask

  task automatic idle(input int inst);
    req_s[inst].req = 1'b0;
    #1;
  endtask

  task automatic chk_cnt(input int inst);
    chk($sformatf("rd_cnt inst%0d", inst), rd_cnt[inst], 32'(rd_exp[inst]));
    chk($sformatf("wr_cnt inst%0d", inst), wr_cnt[inst], 32'(wr_exp[inst]));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; stall[i] = 1'b0; err_clr[i] = 1'b0;
      req_s[i] = '0;
      req_s[i].req = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_gnt inst%0d", i), 32'(resp_s[i].gnt), 32'h0);
      chk($sformatf("reset_rvalid inst%0d", i), 32'(resp_s[i].rvalid), 32'h0);
      chk($sformatf("reset_rdata inst%0d", i), resp_s[i].rdata, 32'h0);
      chk($sformatf("reset_err inst%0d", i), 32'(err[i]), 32'h0);
      chk_cnt(i);
      req_s[i].req = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    // LATENCY=1: basic write/read, byte enables, empty byte enable
    txn(0, 1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, 32'h0, 1, waited);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hCAFE_F00D, 1, waited);
    txn(0, 1'b1, 4'hF, 32'h20, 32'hAAAA_AAAA, 32'h0, 1, waited);
    txn(0, 1'b1, 4'b0101, 32'h20, 32'h1122_3344, 32'h0, 1, waited);
    txn(0, 1'b0, 4'hF, 32'h22, 32'h0, 32'hAA22_AA44, 1, waited);
    txn(0, 1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, 32'h0, 1, waited);
    txn(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hAA22_AA44, 1, waited);
    idle(0);
    chk_cnt(0);

    // Stall with request held
    stall[0] = 1'b1;
    req_s[0].req = 1'b1; req_s[0].we = 1'b0; req_s[0].be = 4'hF;
    req_s[0].addr = 32'h10; req_s[0].wdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("stall_gnt", 32'(resp_s[0].gnt), 32'h0);
      @(negedge clk);
    end
    chk_cnt(0);
    stall[0] = 1'b0;
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hCAFE_F00D, 1, waited);
    chk("unstall_wait", 32'(waited), 32'h0);
    idle(0);
    chk_cnt(0);

    // Out of range: read just past the top, clear, then set-beats-clear
    txn(0, 1'b0, 4'hF, 32'h100, 32'h0, 32'h0, 1, waited);
    idle(0);
    chk("oor_err_set", 32'(err[0]), 32'h1);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    #1;
    chk("oor_err_clr", 32'(err[0]), 32'h0);
    err_clr[0] = 1'b1;
    txn(0, 1'b1, 4'hF, 32'h110, 32'hDEAD_BEEF, 32'h0, 1, waited);
    idle(0);
    err_clr[0] = 1'b0;
    chk("err_set_wins", 32'(err[0]), 32'h1);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'hCAFE_F00D, 1, waited);
    idle(0);
    chk_cnt(0);

    // LATENCY=3: back-to-back traffic and captured read data
    for (int i = 0; i < 6; i++)
      txn(1, 1'b1, 4'hF, 32'h1000 + 32'(4*i), 32'h0101_0101 * 32'(i+1), 32'h0, 1, waited);
    for (int i = 0; i < 6; i++) begin
      txn(1, 1'b0, 4'hF, 32'h1000 + 32'(4*i), 32'h0, 32'h0101_0101 * 32'(i+1), 1, waited);
      chk("b2b_gnt_wait", 32'(waited), 32'h0);
    end
    txn(1, 1'b0, 4'hF, 32'h1008, 32'h0, 32'h0303_0303, 1, waited);
    txn(1, 1'b1, 4'hF, 32'h1008, 32'h5555_AAAA, 32'h0, 1, waited);
    txn(1, 1'b0, 4'hF, 32'h1008, 32'h0, 32'h5555_AAAA, 1, waited);
    txn(1, 1'b0, 4'hF, 32'h0FFC, 32'h0, 32'h0, 1, waited);
    idle(1);
    chk("below_base_err", 32'(err[1]), 32'h1);
    repeat (5) @(negedge clk);
    chk_cnt(1);

    // LATENCY=4: reset while a read is in flight drops it
    txn(2, 1'b0, 4'hF, 32'h0, 32'h0, 32'h0, 0, waited);
    idle(2);
    chk_cnt(2);
    @(negedge clk);
    rst_n[2] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[2] = 1'b1;
    rd_exp[2] = 0;
    wr_exp[2] = 0;
    repeat (8) @(negedge clk);
    #1;
    chk_cnt(2);

    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
